// File: rtl/si_alu_pkg.sv
// si_alu_pkg: shared definitions for the SI ALU arbitration slice.
//   WORD_W       - datapath word width (32)
//   XOR_ROL..    - SI ALU opcode constants (5..8)
//   arb_state_t  - arbiter FSM state encoding
//   op_is_legal  - true for opcodes the SI ALU implements
package si_alu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] XOR_ROL = 4'd5;
  localparam logic [3:0] ROR_XOR = 4'd6;
  localparam logic [3:0] ROL_ADD = 4'd7;
  localparam logic [3:0] SUB_ROR = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= XOR_ROL) && (op <= SUB_ROR);
  endfunction

endpackage

// File: rtl/si_rr_arb2.sv
// si_rr_arb2: two-requester round-robin grant.
//   clk, rst_n - clock, async active-low reset
//   req[1:0]   - requester valid bits
//   accept     - the current grant was taken this cycle; advances the pointer
//   grant[1:0] - one-hot grant (zero when no request)
module si_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // ID granted most recently; resets to 1 so REQ0 wins the first tie.
  logic last_id;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_id ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_id <= 1'b1;
    else if (accept) last_id <= grant[1];
  end

endmodule

// File: rtl/si_alu_arbiter.sv
// si_alu_arbiter: shares one external combinational SI ALU between two
// requesters. A granted request is iterated ITER+1 times through the ALU,
// feeding the result back as the next RS, then returned on the RSP channel.
//   CLK, RST_N                 - clock, async active-low reset
//   REQn_VALID/READY           - per-requester handshake (n=0,1)
//   REQn_RS/RT/ROT_AM/CNTRL/ITER - operands, shift, opcode, passes-1
//   ALU_RS/RT/ROT_AM/CNTRL     - drive to shared ALU (zero outside RUN)
//   ALU_VAL                    - ALU result
//   RSP_VALID/READY/VAL/ID/ERR - result channel
// Optional: `define SI_ALU_ARB_ILLEGAL_CHK_EN to reject opcodes outside 5..8
// with an immediate error response instead of running them.
module si_alu_arbiter
  import si_alu_pkg::*;
#(
  parameter int unsigned ITER_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [WORD_W-1:0] REQ0_RS,
  input  logic [WORD_W-1:0] REQ0_RT,
  input  logic [3:0]        REQ0_ROT_AM,
  input  logic [3:0]        REQ0_CNTRL,
  input  logic [ITER_W-1:0] REQ0_ITER,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [WORD_W-1:0] REQ1_RS,
  input  logic [WORD_W-1:0] REQ1_RT,
  input  logic [3:0]        REQ1_ROT_AM,
  input  logic [3:0]        REQ1_CNTRL,
  input  logic [ITER_W-1:0] REQ1_ITER,
  output logic [WORD_W-1:0] ALU_RS,
  output logic [WORD_W-1:0] ALU_RT,
  output logic [3:0]        ALU_ROT_AM,
  output logic [3:0]        ALU_CNTRL,
  input  logic [WORD_W-1:0] ALU_VAL,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [WORD_W-1:0] RSP_VAL,
  output logic              RSP_ID,
  output logic              RSP_ERR
);

  arb_state_t state, state_nxt;

  logic [1:0]        grant;
  logic              accept;
  logic              sel_id;
  logic [WORD_W-1:0] sel_rs, sel_rt;
  logic [3:0]        sel_rot, sel_cntrl;
  logic [ITER_W-1:0] sel_iter;

  logic [WORD_W-1:0] acc, rt_q;
  logic [3:0]        rot_q, cntrl_q;
  logic [ITER_W-1:0] cnt;
  logic              id_q;
  logic              in_run, in_resp;

  si_rr_arb2 u_arb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .req    ({REQ1_VALID, REQ0_VALID}),
    .accept (accept),
    .grant  (grant)
  );

  // READY is gated by RST_N so it is low for the whole reset window.
  assign REQ0_READY = (state == IDLE) && RST_N && grant[0];
  assign REQ1_READY = (state == IDLE) && RST_N && grant[1];
  assign accept     = (REQ0_READY && REQ0_VALID) || (REQ1_READY && REQ1_VALID);

  assign sel_id    = grant[1];
  assign sel_rs    = sel_id ? REQ1_RS     : REQ0_RS;
  assign sel_rt    = sel_id ? REQ1_RT     : REQ0_RT;
  assign sel_rot   = sel_id ? REQ1_ROT_AM : REQ0_ROT_AM;
  assign sel_cntrl = sel_id ? REQ1_CNTRL  : REQ0_CNTRL;
  assign sel_iter  = sel_id ? REQ1_ITER   : REQ0_ITER;

`ifdef SI_ALU_ARB_ILLEGAL_CHK_EN
  logic sel_bad;
  logic err_q;
  assign sel_bad = !op_is_legal(sel_cntrl);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
`ifdef SI_ALU_ARB_ILLEGAL_CHK_EN
          if (sel_bad) state_nxt = RESP;
`endif
        end
      end
      RUN:     if (cnt == '0) state_nxt = RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc     <= '0;
      rt_q    <= '0;
      rot_q   <= '0;
      cntrl_q <= '0;
      cnt     <= '0;
      id_q    <= 1'b0;
`ifdef SI_ALU_ARB_ILLEGAL_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= sel_rs;
            rt_q    <= sel_rt;
            rot_q   <= sel_rot;
            cntrl_q <= sel_cntrl;
            cnt     <= sel_iter;
            id_q    <= sel_id;
`ifdef SI_ALU_ARB_ILLEGAL_CHK_EN
            err_q   <= sel_bad;
            if (sel_bad) acc <= '0;
`endif
          end
        end
        RUN: begin
          acc <= ALU_VAL;
          cnt <= cnt - ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_run  = (state == RUN);
  assign in_resp = (state == RESP);

  assign ALU_RS     = in_run ? acc     : '0;
  assign ALU_RT     = in_run ? rt_q    : '0;
  assign ALU_ROT_AM = in_run ? rot_q   : '0;
  assign ALU_CNTRL  = in_run ? cntrl_q : '0;

  assign RSP_VALID = in_resp;
  assign RSP_VAL   = in_resp ? acc : '0;
  assign RSP_ID    = in_resp && id_q;
`ifdef SI_ALU_ARB_ILLEGAL_CHK_EN
  assign RSP_ERR   = in_resp && err_q;
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule
